ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 SHALL have these decode-side inputs: valid_d 1; rd1_d 32; rd2_d 32; immext_d 32; pc_d 32; rs1_d 5; rs2_d 5; rd_d 5; alucontrol_d 3; alusrc_d 1; regwrite_d 1; memwrite_d 1; resultsrc_d 2.
REQ-003 SHALL have these control inputs: stall_e 1 (downstream hold); flush_e 1 (branch/jump kill).
REQ-004 SHALL have these forwarding inputs: regwrite_m 1; rd_m 5; aluresult_m 32; regwrite_w 1; rd_w 5; result_w 32.
REQ-005 SHALL drive these ALU-facing outputs: srca_e 32; srcb_e 32; alucontrol_e 3.
REQ-006 SHALL drive these pass-through outputs: valid_e 1; writedata_e 32; pc_e 32; rd_e 5; regwrite_e 1; memwrite_e 1; resultsrc_e 2.
REQ-007 SHALL drive stall_d 1 (load-use hazard; decode and fetch hold while high).

Function
REQ-008 SHALL register all decode-side fields on the rising clk edge into an E-stage register, with 1-cycle latency from D inputs to E outputs.
REQ-009 SHALL apply update priority per edge: reset, then stall_e (hold all fields), then flush_e or stall_d (load bubble), then normal load.
REQ-010 SHALL load a bubble as all fields zero: valid_e=0, regwrite_e=0, memwrite_e=0, alucontrol_e=000, resultsrc_e=00, rd_e=0.
REQ-011 SHALL compute forwarding combinationally from the registered rs1_e/rs2_e. Per operand: M match (regwrite_m, rd_m!=0, rd_m==rsX_e) selects aluresult_m; else W match (same rule) selects result_w; else the registered rdX_e.
REQ-012 SHALL give the M stage priority over the W stage when both match.
REQ-013 SHALL never forward for register x0: an operand with rsX_e=0 SHALL read the registered value.
REQ-014 SHALL drive srca_e with forwarded operand 1.
REQ-015 SHALL drive srcb_e with immext_e when alusrc_e=1, and with forwarded operand 2 otherwise.
REQ-016 SHALL drive writedata_e with forwarded operand 2 regardless of alusrc_e.
REQ-017 SHALL assert stall_d combinationally when all of these hold: valid_e, resultsrc_e==01 (load), rd_e!=0, valid_d, and (rd_e==rs1_d or rd_e==rs2_d).
REQ-018 SHALL insert a bubble into E while stall_d=1. After one edge stall_d SHALL deassert, and the D instruction SHALL load on the next edge.
REQ-019 SHALL let flush_e and stall_d together produce a single bubble.
REQ-020 SHALL, when stall_e=1, hold all E fields; forwarding outputs SHALL keep tracking the M/W inputs.

Reset
REQ-021 SHALL, on reset at any edge (including mid-stall), clear all E fields to zero, identical to a bubble.
REQ-022 SHALL, while reset is high, drive valid_e=0, regwrite_e=0, memwrite_e=0, stall_d=0.

Structure
REQ-023 SHALL take from shared package riscv_pkg: ALU op encodings (ADD=000 … SRL=111), RESULTSRC_ALU=00/LOAD=01/PC4=10, and forward-select encoding (REG=00, W=01, M=10).
REQ-024 SHALL implement forwarding as one sub-module, fwd_mux (register index, registered value, M/W ports → 32-bit operand), instantiated twice.

Verification
REQ-025 SHALL be covered by this M-forward scenario: E add with rs1=5, rd1_d=0x10; regwrite_m=1, rd_m=5, aluresult_m=0x55 → srca_e=0x55.
REQ-026 SHALL be covered by this priority scenario: rs2=7 matches both M (0xAA) and W (0xBB), alusrc=0 → srcb_e=0xAA and writedata_e=0xAA. With alusrc=1 and immext=0x4 → srcb_e=0x4, writedata_e=0xAA.
REQ-027 SHALL be covered by this x0 scenario: rs1=0, rd_m=0, regwrite_m=1, aluresult_m=0xFFFF_FFFF → srca_e=0.
REQ-028 SHALL be covered by this load-use scenario: E load with rd_e=3, D with rs2_d=3 and valid_d=1 → stall_d=1 for one cycle, then valid_e=0 with regwrite_e=0, then the D instruction appears in E.
REQ-029 SHALL be covered by this stall/flush scenario: stall_e=1 for 3 cycles → E fields unchanged. Then flush_e=1 → valid_e=0 and memwrite_e=0 next cycle.
REQ-030 SHALL be covered by this reset scenario: reset during stall_e=1 → all outputs zero after the edge, and stall_d=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU, result-source and forwarding encodings
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    RESULTSRC_ALU  = 2'b00,
    RESULTSRC_LOAD = 2'b01,
    RESULTSRC_PC4  = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // E-stage pipeline register contents; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immext;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alucontrol;
    logic        alusrc;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
  } e_reg_t;

  // M is checked first so the younger result wins; x0 never forwards.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic       regwrite_m,
    input logic [4:0] rd_m,
    input logic       regwrite_w,
    input logic [4:0] rd_w
  );
    if (rs == 5'd0)                          return FWD_REG;
    else if (regwrite_m && (rd_m == rs))     return FWD_M;
    else if (regwrite_w && (rd_w == rs))     return FWD_W;
    else                                     return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - one operand's forwarding select from M, W or the register file value
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic [31:0] regval,
  input  logic        regwrite_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] aluresult_m,
  input  logic        regwrite_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic [31:0] operand
);

  fwd_sel_t sel;

  always_comb begin
    sel = fwd_select(rs, regwrite_m, rd_m, regwrite_w, rd_w);
    operand = regval;
    case (sel)
      FWD_M:   operand = aluresult_m;
      FWD_W:   operand = result_w;
      default: operand = regval;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - E-stage register with operand forwarding and load-use stall detection
module ex_operand_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] immext_d,
  input  logic [31:0] pc_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic [2:0]  alucontrol_d,
  input  logic        alusrc_d,
  input  logic        regwrite_d,
  input  logic        memwrite_d,
  input  logic [1:0]  resultsrc_d,
  input  logic        stall_e,
  input  logic        flush_e,
  input  logic        regwrite_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] aluresult_m,
  input  logic        regwrite_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic [31:0] srca_e,
  output logic [31:0] srcb_e,
  output logic [2:0]  alucontrol_e,
  output logic        valid_e,
  output logic [31:0] writedata_e,
  output logic [31:0] pc_e,
  output logic [4:0]  rd_e,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic [1:0]  resultsrc_e,
  output logic        stall_d
);

  e_reg_t e_q, e_d, d_fields;
  logic   load_use;
  logic [31:0] op1, op2;

  always_comb begin
    d_fields            = '0;
    d_fields.valid      = valid_d;
    d_fields.rd1        = rd1_d;
    d_fields.rd2        = rd2_d;
    d_fields.immext     = immext_d;
    d_fields.pc         = pc_d;
    d_fields.rs1        = rs1_d;
    d_fields.rs2        = rs2_d;
    d_fields.rd         = rd_d;
    d_fields.alucontrol = alucontrol_d;
    d_fields.alusrc     = alusrc_d;
    d_fields.regwrite   = regwrite_d;
    d_fields.memwrite   = memwrite_d;
    d_fields.resultsrc  = resultsrc_d;
  end

  assign load_use = e_q.valid && (e_q.resultsrc == RESULTSRC_LOAD) && (e_q.rd != 5'd0) &&
                    valid_d && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

  always_comb begin
    e_d = e_q;
    if (stall_e)                  e_d = e_q;
    else if (flush_e || load_use) e_d = '0;
    else                          e_d = d_fields;
  end

  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  fwd_mux u_fwd_a (
    .rs(e_q.rs1), .regval(e_q.rd1),
    .regwrite_m(regwrite_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .operand(op1)
  );

  fwd_mux u_fwd_b (
    .rs(e_q.rs2), .regval(e_q.rd2),
    .regwrite_m(regwrite_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .operand(op2)
  );

  assign srca_e       = op1;
  assign srcb_e       = e_q.alusrc ? e_q.immext : op2;
  assign writedata_e  = op2;
  assign alucontrol_e = e_q.alucontrol;
  assign pc_e         = e_q.pc;
  assign rd_e         = e_q.rd;
  assign resultsrc_e  = e_q.resultsrc;
  // Gated so the control strobes are quiet even before the first reset edge.
  assign valid_e      = e_q.valid & ~reset;
  assign regwrite_e   = e_q.regwrite & ~reset;
  assign memwrite_e   = e_q.memwrite & ~reset;
  assign stall_d      = load_use & ~reset;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alucontrol_d;
  logic        alusrc_d, regwrite_d, memwrite_d;
  logic [1:0]  resultsrc_d;
  logic        stall_e, flush_e;
  logic        regwrite_m, regwrite_w;
  logic [4:0]  rd_m, rd_w;
  logic [31:0] aluresult_m, result_w;
  logic [31:0] srca_e, srcb_e, writedata_e, pc_e;
  logic [2:0]  alucontrol_e;
  logic        valid_e, regwrite_e, memwrite_e, stall_d;
  logic [4:0]  rd_e;
  logic [1:0]  resultsrc_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .resultsrc_d(resultsrc_d), .stall_e(stall_e), .flush_e(flush_e),
    .regwrite_m(regwrite_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .valid_e(valid_e), .writedata_e(writedata_e), .pc_e(pc_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e),
    .stall_d(stall_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    valid_d = 0; rd1_d = 0; rd2_d = 0; immext_d = 0; pc_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; alucontrol_d = 0;
    alusrc_d = 0; regwrite_d = 0; memwrite_d = 0; resultsrc_d = 0;
  endtask

  task automatic clear_fwd();
    regwrite_m = 0; rd_m = 0; aluresult_m = 0;
    regwrite_w = 0; rd_w = 0; result_w = 0;
  endtask

  initial begin
    reset = 1; stall_e = 0; flush_e = 0;
    clear_d(); clear_fwd();
    #1;
    check("rst_pre_valid", {31'd0, valid_e}, 32'd0);
    check("rst_pre_stall_d", {31'd0, stall_d}, 32'd0);
    tick(); tick();
    check("rst_valid", {31'd0, valid_e}, 32'd0);
    check("rst_regwrite", {31'd0, regwrite_e}, 32'd0);
    check("rst_memwrite", {31'd0, memwrite_e}, 32'd0);
    check("rst_srca", srca_e, 32'd0);
    check("rst_pc", pc_e, 32'd0);

    // M and W forwarding
    reset = 0;
    valid_d = 1; rs1_d = 5; rd1_d = 32'h10; rs2_d = 6; rd2_d = 32'h20;
    rd_d = 8; regwrite_d = 1; pc_d = 32'h100; alucontrol_d = 3'b001;
    tick();
    check("ld_valid", {31'd0, valid_e}, 32'd1);
    check("ld_pc", pc_e, 32'h100);
    check("ld_rd", {27'd0, rd_e}, 32'd8);
    check("ld_aluctl", {29'd0, alucontrol_e}, 32'd1);
    check("ld_srca_reg", srca_e, 32'h10);
    check("ld_srcb_reg", srcb_e, 32'h20);
    regwrite_m = 1; rd_m = 5; aluresult_m = 32'h55;
    #1;
    check("fwd_m_srca", srca_e, 32'h55);
    check("fwd_m_srcb_untouched", srcb_e, 32'h20);
    clear_fwd();
    regwrite_w = 1; rd_w = 6; result_w = 32'h66;
    #1;
    check("fwd_w_srcb", srcb_e, 32'h66);
    check("fwd_w_wdata", writedata_e, 32'h66);
    regwrite_w = 0;
    #1;
    check("fwd_w_off", srcb_e, 32'h20);

    // M over W priority, then immediate select
    clear_fwd(); clear_d();
    valid_d = 1; rs1_d = 1; rd1_d = 32'h11; rs2_d = 7; rd2_d = 32'h77; rd_d = 9;
    tick();
    regwrite_m = 1; rd_m = 7; aluresult_m = 32'hAA;
    regwrite_w = 1; rd_w = 7; result_w = 32'hBB;
    #1;
    check("prio_srcb", srcb_e, 32'hAA);
    check("prio_wdata", writedata_e, 32'hAA);
    check("prio_srca_reg", srca_e, 32'h11);
    alusrc_d = 1; immext_d = 32'h4;
    tick();
    check("imm_srcb", srcb_e, 32'h4);
    check("imm_wdata", writedata_e, 32'hAA);
    regwrite_m = 0;
    #1;
    check("w_only_wdata", writedata_e, 32'hBB);

    // x0 never forwards
    clear_fwd(); clear_d();
    valid_d = 1; rs1_d = 0; rd1_d = 32'h0; rs2_d = 0; rd2_d = 32'h0;
    tick();
    regwrite_m = 1; rd_m = 0; aluresult_m = 32'hFFFF_FFFF;
    regwrite_w = 1; rd_w = 0; result_w = 32'hFFFF_FFFF;
    #1;
    check("x0_srca", srca_e, 32'd0);
    check("x0_wdata", writedata_e, 32'd0);

    // load-use: one bubble, then the dependent instruction
    clear_fwd(); clear_d();
    valid_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 3; regwrite_d = 1; resultsrc_d = 2'b01;
    tick();
    check("lu_load_in_e", {30'd0, resultsrc_e}, 32'd1);
    clear_d();
    valid_d = 0; rs1_d = 9; rs2_d = 3; rd_d = 4; regwrite_d = 1;
    rd1_d = 32'h99; rd2_d = 32'h33; pc_d = 32'h200;
    #1;
    check("lu_invalid_d_no_stall", {31'd0, stall_d}, 32'd0);
    valid_d = 1;
    #1;
    check("lu_stall_d", {31'd0, stall_d}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, valid_e}, 32'd0);
    check("lu_bubble_regwrite", {31'd0, regwrite_e}, 32'd0);
    check("lu_stall_released", {31'd0, stall_d}, 32'd0);
    tick();
    check("lu_dep_valid", {31'd0, valid_e}, 32'd1);
    check("lu_dep_pc", pc_e, 32'h200);
    check("lu_dep_rd", {27'd0, rd_e}, 32'd4);

    // stall_e holds, flush_e kills
    clear_d();
    valid_d = 1; memwrite_d = 1; pc_d = 32'h300; rs2_d = 5; rd2_d = 32'h5;
    tick();
    check("st_memwrite", {31'd0, memwrite_e}, 32'd1);
    stall_e = 1; pc_d = 32'h400; memwrite_d = 0; rd2_d = 32'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_pc", pc_e, 32'h300);
      check("st_hold_memwrite", {31'd0, memwrite_e}, 32'd1);
    end
    regwrite_m = 1; rd_m = 5; aluresult_m = 32'h5A;
    #1;
    check("st_fwd_tracks", writedata_e, 32'h5A);
    clear_fwd();
    stall_e = 0; flush_e = 1;
    tick();
    check("fl_valid", {31'd0, valid_e}, 32'd0);
    check("fl_memwrite", {31'd0, memwrite_e}, 32'd0);
    check("fl_pc", pc_e, 32'd0);
    flush_e = 0;

    // reset while stalled, with a load-use pending
    clear_d();
    valid_d = 1; rd_d = 3; regwrite_d = 1; resultsrc_d = 2'b01; pc_d = 32'h500;
    tick();
    clear_d();
    valid_d = 1; rs1_d = 3; pc_d = 32'h600;
    stall_e = 1;
    #1;
    check("rs_stall_d_before", {31'd0, stall_d}, 32'd1);
    reset = 1;
    #1;
    check("rs_stall_d_during", {31'd0, stall_d}, 32'd0);
    tick();
    check("rs_valid", {31'd0, valid_e}, 32'd0);
    check("rs_regwrite", {31'd0, regwrite_e}, 32'd0);
    check("rs_pc", pc_e, 32'd0);
    check("rs_rd", {27'd0, rd_e}, 32'd0);
    check("rs_resultsrc", {30'd0, resultsrc_e}, 32'd0);
    check("rs_srca", srca_e, 32'd0);
    check("rs_stall_d", {31'd0, stall_d}, 32'd0);
    reset = 0; stall_e = 0;
    tick();
    check("rs_stall_d_after", {31'd0, stall_d}, 32'd0);
    check("rs_reload_pc", pc_e, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
